// File: rtl/mcu_pkg.sv
// mcu_pkg: shared state codes and load/store opcode pattern for the mcu and decode unit
package mcu_pkg;
  localparam logic [1:0] WAIT_PREFIX = 2'b10;
  localparam logic [2:0] EXEC_CODE = 3'b011;
  localparam logic [6:0] LSU_OPCODE = 7'b0000011;
  localparam logic [6:0] LSU_OPCODE_MASK = 7'b1011111;
  typedef enum logic [2:0] {
    S_FETCH = 3'b000,
    S_FETCH_WAIT = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC = EXEC_CODE,
    S_WAIT_VALID = {WAIT_PREFIX, 1'b0},
    S_WAIT_READY = {WAIT_PREFIX, 1'b1},
    S_WRITEBACK = 3'b110,
    S_ERROR = 3'b111
  } state_t;
  function automatic logic is_lsu_op(input logic [6:0] op);
    return (op & LSU_OPCODE_MASK) == LSU_OPCODE;
  endfunction
  function automatic logic in_lsu_wait(input state_t s);
    return s[2:1] == WAIT_PREFIX;
  endfunction
endpackage

// File: rtl/mcu_lsu_timer.sv
// mcu_lsu_timer: 8-bit LSU wait counter flagging the last cycle before timeout
module mcu_lsu_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  logic [7:0] cnt;
  // count wait cycles; cleared on entry to the wait pair and held elsewhere
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  assign tc = cnt == LIMIT - 8'd1;
endmodule

// File: rtl/mcu.sv
// mcu: multi-cycle fetch/decode/execute sequencer with LSU timeout and retire counter
module mcu
  import mcu_pkg::*;
#(
  parameter logic [7:0] LSU_TIMEOUT = 8'd255,
  parameter int INSTRET_W = 32
) (
  input  logic                 MCU_CLOCK_50,
  input  logic                 MCU_RESET_InLow,
  input  logic [6:0]           MCU_Opcode_InBUS,
  input  logic                 MCU_Imem_Ready_In,
  input  logic                 MCU_Lsu_Valid_In,
  input  logic                 MCU_Lsu_Ready_In,
  output logic [2:0]           MCU_State_OutBUS,
  output logic                 MCU_Imem_Req_Out,
  output logic                 MCU_Ir_Write_Out,
  output logic                 MCU_Pc_Write_Out,
  output logic                 MCU_Lsu_Error_Out,
  output logic [INSTRET_W-1:0] MCU_Instret_OutBUS
);
  state_t state, state_nxt;
  logic tc;
  mcu_lsu_timer #(.LIMIT(LSU_TIMEOUT)) u_timer (
    .clk(MCU_CLOCK_50),
    .rst_n(MCU_RESET_InLow),
    .clear(state == S_EXEC && is_lsu_op(MCU_Opcode_InBUS)),
    .enable(in_lsu_wait(state)),
    .tc(tc)
  );
  // state register
  always_ff @(posedge MCU_CLOCK_50 or negedge MCU_RESET_InLow)
    if (!MCU_RESET_InLow) state <= S_FETCH;
    else state <= state_nxt;
  // next-state logic; an arriving handshake beats a simultaneous timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH:      state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: state_nxt = MCU_Imem_Ready_In ? S_DECODE : S_FETCH_WAIT;
      S_DECODE:     state_nxt = S_EXEC;
      S_EXEC:       state_nxt = is_lsu_op(MCU_Opcode_InBUS) ? S_WAIT_VALID : S_WRITEBACK;
      S_WAIT_VALID: state_nxt = MCU_Lsu_Valid_In ? S_WAIT_READY : tc ? S_ERROR : S_WAIT_VALID;
      S_WAIT_READY: state_nxt = MCU_Lsu_Ready_In ? S_WRITEBACK : tc ? S_ERROR : S_WAIT_READY;
      S_WRITEBACK:  state_nxt = S_FETCH;
      S_ERROR:      state_nxt = S_ERROR;
      default:      state_nxt = S_FETCH;
    endcase
  end
  // sticky timeout flag, set on the edge that enters ERROR
  always_ff @(posedge MCU_CLOCK_50 or negedge MCU_RESET_InLow)
    if (!MCU_RESET_InLow) MCU_Lsu_Error_Out <= 1'b0;
    else if (state_nxt == S_ERROR) MCU_Lsu_Error_Out <= 1'b1;
  // retire counter, bumped on every edge leaving WRITEBACK
  always_ff @(posedge MCU_CLOCK_50 or negedge MCU_RESET_InLow)
    if (!MCU_RESET_InLow) MCU_Instret_OutBUS <= '0;
    else if (state == S_WRITEBACK) MCU_Instret_OutBUS <= MCU_Instret_OutBUS + INSTRET_W'(1);
  assign MCU_State_OutBUS = state;
  assign MCU_Imem_Req_Out = state == S_FETCH || state == S_FETCH_WAIT;
  assign MCU_Ir_Write_Out = state == S_FETCH_WAIT && MCU_Imem_Ready_In;
  assign MCU_Pc_Write_Out = state == S_WRITEBACK;
endmodule

// File: doc/mcu.md
MCU -- requirements
Module: mcu

Interface
REQ-001 Parameter LSU_TIMEOUT, default 8'd255, maximum number of cycles spent in the LSU wait states before the error state.
REQ-002 Parameter INSTRET_W, default 32, width of the retired-instruction counter.
REQ-003 MCU_CLOCK_50  input  1  single system clock; all state updates on its rising edge.
REQ-004 MCU_RESET_InLow  input  1  reset, asynchronous assertion, active-low.
REQ-005 MCU_Opcode_InBUS  input  7  opcode field of the instruction register.
REQ-006 MCU_Imem_Ready_In  input  1  instruction memory has the requested word available.
REQ-007 MCU_Lsu_Valid_In  input  1  data-memory response valid.
REQ-008 MCU_Lsu_Ready_In  input  1  data memory accepts completion; LSU transaction done.
REQ-009 MCU_State_OutBUS  output  3  current state code, drives the decode unit's state input.
REQ-010 MCU_Imem_Req_Out  output  1  instruction fetch request.
REQ-011 MCU_Ir_Write_Out  output  1  instruction register load strobe.
REQ-012 MCU_Pc_Write_Out  output  1  PC update strobe.
REQ-013 MCU_Lsu_Error_Out  output  1  sticky LSU timeout flag.
REQ-014 MCU_Instret_OutBUS  output  INSTRET_W  retired-instruction count.

Function
REQ-015 State encoding SHALL be: FETCH 000, FETCH_WAIT 001, DECODE 010, EXEC 011, WAIT_VALID 100, WAIT_READY 101, WRITEBACK 110, ERROR 111.
REQ-016 MCU_State_OutBUS SHALL be the state register, with no combinational path from inputs.
REQ-017 FETCH SHALL go to FETCH_WAIT unconditionally after 1 cycle.
REQ-018 FETCH_WAIT SHALL stay while MCU_Imem_Ready_In=0, and go to DECODE on the edge where it is 1.
REQ-019 DECODE SHALL go to EXEC unconditionally after 1 cycle.
REQ-020 EXEC SHALL go to WAIT_VALID when the opcode matches 0?00011 (load/store), and to WRITEBACK otherwise, including illegal opcodes.
REQ-021 WAIT_VALID SHALL go to WAIT_READY when MCU_Lsu_Valid_In=1.
REQ-022 WAIT_READY SHALL go to WRITEBACK when MCU_Lsu_Ready_In=1.
REQ-023 WRITEBACK SHALL go to FETCH unconditionally after 1 cycle.
REQ-024 ERROR SHALL be absorbing until reset.
REQ-025 MCU_Imem_Req_Out SHALL be 1 in FETCH and FETCH_WAIT only, decoded from the state alone.
REQ-026 MCU_Ir_Write_Out SHALL be high for exactly one cycle: (state==FETCH_WAIT) & MCU_Imem_Ready_In, combinational.
REQ-027 MCU_Pc_Write_Out SHALL be 1 exactly while in WRITEBACK.
REQ-028 Timeout counter (8 bit):
  - cleared when entering WAIT_VALID;
  - increments each cycle in WAIT_VALID and WAIT_READY;
  - not cleared between those two states.
REQ-029 When the counter equals LSU_TIMEOUT-1 and the awaited handshake input is 0, next state SHALL be ERROR and MCU_Lsu_Error_Out SHALL set to 1 on that edge.
REQ-030 If the awaited handshake input is 1 in the same cycle as timeout, the handshake SHALL win: no error, normal transition.
REQ-031 MCU_Instret_OutBUS SHALL increment by 1 on each edge leaving WRITEBACK, wrapping from all-ones to 0.
REQ-032 Minimum instruction latency, FETCH to FETCH:
  - non-LSU with Imem_Ready tied high: 5 cycles;
  - LSU with valid/ready tied high: 7 cycles.

Reset
REQ-033 While MCU_RESET_InLow=0, all registers SHALL clear asynchronously:
  - state = FETCH;
  - timeout counter = 0;
  - MCU_Instret_OutBUS = 0;
  - MCU_Lsu_Error_Out = 0.
REQ-034 Combinational outputs during reset SHALL follow state FETCH: Imem_Req=1, Ir_Write=0, Pc_Write=0.
REQ-035 Reset asserted in any state, including mid-LSU-wait and ERROR, SHALL abort the instruction with no Pc_Write and no instret increment.
REQ-036 Deassertion SHALL be synchronised externally, and first FETCH->FETCH_WAIT SHALL occur on the first rising edge after release.

Structure
REQ-037 State codes and the load/store opcode pattern SHALL live in a shared package/include used by both mcu and the decode unit.
  - EXEC=011 and the WAIT pair 10? SHALL have a single definition.
REQ-038 The timeout counter SHALL be one sub-module, mcu_lsu_timer, with ports clear, enable, terminal-count out.
REQ-039 No other sub-modules SHALL be used; next-state logic and output decode SHALL reside in mcu.

Verification
REQ-040 Stimulus: reset release, Imem_Ready=1, opcode 0110011 repeated.
  - Response: state sequence 000,001,010,011,110,000; Pc_Write every 5th cycle; instret=4 after 20 cycles.
REQ-041 Stimulus: opcode 0000011, Imem_Ready=1, Lsu_Valid raised 3 cycles after entering 100, Lsu_Ready raised 2 cycles later.
  - Response: states 100 x4, 101 x2, then 110; instret +1.
REQ-042 Stimulus: opcode 0100011, Lsu_Valid held 0, LSU_TIMEOUT=4.
  - Response: state 111 four cycles after entering 100; Lsu_Error=1 sticky; instret unchanged.
REQ-043 Stimulus: same as REQ-042 but Lsu_Valid=1 exactly on the timeout cycle.
  - Response: state 101, Lsu_Error=0.
REQ-044 Stimulus: MCU_RESET_InLow pulsed low mid-WAIT_READY with instret preset to 32'hFFFFFFFF.
  - Response: immediate state 000, instret=0, no Pc_Write pulse.
REQ-045 Stimulus: Imem_Ready held 0 for 10 cycles then 1.
  - Response: Imem_Req=1 for 11 cycles; single one-cycle Ir_Write on the ready edge.
